// File: rtl/mirror_spi_pkg.sv
// rtl/mirror_spi_pkg.sv - shared defaults, address width helper and FSM state type for the mirror SPI sender
package mirror_spi_pkg;

  localparam int COLS_DEFAULT    = 40;
  localparam int ROWS_DEFAULT    = 15;
  localparam int CLK_DIV_DEFAULT = 2;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    LEAD,
    SHIFT,
    TRAIL
  } state_t;

  function automatic int addr_w(input int cells);
    return (cells > 1) ? $clog2(cells) : 1;
  endfunction

endpackage

// File: rtl/spi_sclk_divider.sv
// rtl/spi_sclk_divider.sv - SCLK half-period counter with end-of-phase rise/fall strobes
module spi_sclk_divider #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall,
  output logic phase_start
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          phase_q;
  logic          tick;

  assign tick = (cnt_q == LAST);

  // Disabling holds the divider at the start of a low phase, so every enable begins a full low half-period.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (tick) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // rise/fall mark the last cycle of a phase; the sclk transition follows at the next edge.
  assign sclk        = phase_q;
  assign rise        = en & tick & ~phase_q;
  assign fall        = en & tick & phase_q;
  assign phase_start = en & (cnt_q == '0);

endmodule

// File: rtl/mirror_spi_sender.sv
// rtl/mirror_spi_sender.sv - SPI master streaming a column-major character frame, LSB first, under one ss window
module mirror_spi_sender
  import mirror_spi_pkg::*;
#(
  parameter int COLS    = COLS_DEFAULT,
  parameter int ROWS    = ROWS_DEFAULT,
  parameter int CLK_DIV = CLK_DIV_DEFAULT,
  parameter int ADDR_W  = addr_w(COLS * ROWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              sclk,
  output logic              ss,
  output logic              mosi
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        bit_q;
  logic [7:0]        shift_q;
  logic [7:0]        hold_q;
  logic              more_q;
  logic              pf_q;
  logic              done_q;

  logic div_en, div_sclk, div_rise, div_fall, div_first;
  logic accept, prefetch, lead_load;

  assign div_en = (state_q == LEAD) || (state_q == SHIFT) || (state_q == TRAIL);

  spi_sclk_divider #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .en         (div_en),
    .sclk       (div_sclk),
    .rise       (div_rise),
    .fall       (div_fall),
    .phase_start(div_first)
  );

  // A start coinciding with the done pulse is dropped so busy always shows a gap between frames.
  assign accept    = (state_q == IDLE) && start && !done_q;
  assign lead_load = (state_q == LEAD) && div_first;
  assign prefetch  = (state_q == SHIFT) && div_sclk && div_first &&
                     (bit_q == 3'd0) && (addr_q != LAST_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = (state_q != IDLE) || done_q;
    done    = done_q;
    ss      = 1'b1;
    mosi    = 1'b0;
    rd_en   = 1'b0;
    rd_addr = addr_q;
    sclk    = div_sclk;
    case (state_q)
      IDLE: begin
        if (accept) state_d = PRIME;
      end
      PRIME: begin
        rd_en   = 1'b1;
        state_d = LEAD;
      end
      LEAD: begin
        ss   = 1'b0;
        // First LEAD cycle drives the freshly returned byte before it lands in the shift register.
        mosi = div_first ? rd_data[0] : shift_q[0];
        if (div_rise) state_d = SHIFT;
      end
      SHIFT: begin
        ss   = 1'b0;
        mosi = shift_q[0];
        if (prefetch) begin
          rd_en   = 1'b1;
          rd_addr = addr_q + 1'b1;
        end
        if (div_fall && (bit_q == 3'd7) && !more_q) state_d = TRAIL;
      end
      TRAIL: begin
        ss = 1'b0;
        if (div_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // more_q records that the next cell was fetched during the current byte; without it the frame ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      hold_q  <= 8'd0;
      more_q  <= 1'b0;
      pf_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state_q == TRAIL) && div_rise;
      pf_q   <= prefetch;
      if (pf_q) hold_q <= rd_data;

      if (accept) begin
        addr_q <= '0;
        more_q <= 1'b0;
      end else if (prefetch) begin
        addr_q <= addr_q + 1'b1;
        more_q <= 1'b1;
      end

      if (lead_load) begin
        shift_q <= rd_data;
        bit_q   <= 3'd0;
      end else if ((state_q == SHIFT) && div_fall) begin
        bit_q <= bit_q + 1'b1;
        if (bit_q == 3'd7) begin
          shift_q <= hold_q;
          more_q  <= 1'b0;
        end else begin
          shift_q <= {1'b0, shift_q[7:1]};
        end
      end
    end
  end

endmodule

// File: tb/tb_mirror_spi_sender.sv
// tb/tb_mirror_spi_sender.sv - scoreboard bench: default 40x15 sender plus a 2x2 sender with CLK_DIV=5
module tb_mirror_spi_sender;

  localparam int DIV_A = 2;
  localparam int DIV_B = 5;

  logic clk = 1'b0;
  logic rst;
  logic start_a, start_b;

  logic       busy_a, done_a, rd_en_a, sclk_a, ss_a, mosi_a;
  logic [9:0] rd_addr_a;
  logic [7:0] rd_data_a = 8'd0;
  logic       busy_b, done_b, rd_en_b, sclk_b, ss_b, mosi_b;
  logic [1:0] rd_addr_b;
  logic [7:0] rd_data_b = 8'd0;

  logic [7:0] mem_a [600];
  logic [7:0] mem_b [4];
  logic [7:0] exp_a [$];
  logic [7:0] exp_b [$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  int         rx_cnt   [2];
  int         rden_cnt [2];
  int         done_cnt [2];
  int         done_cyc [2];
  int         run_len  [2];
  int         high_cnt [2];
  int         rx_bits  [2];
  logic [7:0] rx_sr    [2];
  logic [1:0] sclk_p, ss_p, mosi_p, rden_p;
  logic [1:0] sclk_v, ss_v, mosi_v, rden_v, done_v;
  logic [7:0] mon_e;

  assign sclk_v = {sclk_b, sclk_a};
  assign ss_v   = {ss_b, ss_a};
  assign mosi_v = {mosi_b, mosi_a};
  assign rden_v = {rd_en_b, rd_en_a};
  assign done_v = {done_b, done_a};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mirror_spi_sender dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .sclk(sclk_a), .ss(ss_a), .mosi(mosi_a)
  );

  mirror_spi_sender #(.COLS(2), .ROWS(2), .CLK_DIV(DIV_B)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .sclk(sclk_b), .ss(ss_b), .mosi(mosi_b)
  );

  always @(posedge clk) begin
    if (rd_en_a) rd_data_a <= mem_a[rd_addr_a];
    if (rd_en_b) rd_data_b <= mem_b[rd_addr_b];
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Slave model and line monitor: samples mosi on sclk rises, pops the scoreboard per byte.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rden_v[d]) begin
        rden_cnt[d]++;
        chk("rd_en_back_to_back", int'(rden_p[d]), 0);
      end
      if (done_v[d]) begin
        done_cnt[d]++;
        done_cyc[d] = cyc;
        chk("trail_len", run_len[d], (d == 0) ? DIV_A : DIV_B);
      end
      if (ss_v[d]) begin
        rx_bits[d] = 0;
      end else begin
        if (mosi_v[d]) high_cnt[d]++;
        if (sclk_v[d] && !sclk_p[d]) begin
          rx_sr[d] = {mosi_v[d], rx_sr[d][7:1]};
          rx_bits[d]++;
          if (rx_bits[d] == 8) begin
            rx_bits[d] = 0;
            rx_cnt[d]++;
            if (d == 0) begin
              chk("rx_byte_expected_a", int'(exp_a.size() > 0), 1);
              if (exp_a.size() > 0) begin
                mon_e = exp_a.pop_front();
                chk("rx_byte_a", int'(rx_sr[d]), int'(mon_e));
              end
            end else begin
              chk("rx_byte_expected_b", int'(exp_b.size() > 0), 1);
              if (exp_b.size() > 0) begin
                mon_e = exp_b.pop_front();
                chk("rx_byte_b", int'(rx_sr[d]), int'(mon_e));
              end
            end
          end
        end
        if (!ss_p[d]) begin
          if (mosi_v[d] !== mosi_p[d]) chk("mosi_change_on_fall", int'({sclk_p[d], sclk_v[d]}), 2);
          if (sclk_v[d] !== sclk_p[d]) begin
            chk("sclk_phase_len", run_len[d], (d == 0) ? DIV_A : DIV_B);
            run_len[d] = 1;
          end else begin
            run_len[d]++;
          end
        end else begin
          run_len[d] = 1;
        end
      end
    end
    sclk_p = sclk_v;
    ss_p   = ss_v;
    mosi_p = mosi_v;
    rden_p = rden_v;
  end

  task automatic wait_done(input int d, input int limit);
    int n = 0;
    while (done_cnt[d] == 0 && n < limit) begin
      step(1);
      n++;
    end
    chk("done_within_budget", done_cnt[d], 1);
  endtask

  task automatic run_b(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3);
    int t0;
    mem_b[0] = b0; mem_b[1] = b1; mem_b[2] = b2; mem_b[3] = b3;
    exp_b.push_back(b0); exp_b.push_back(b1); exp_b.push_back(b2); exp_b.push_back(b3);
    rx_cnt[1] = 0; rden_cnt[1] = 0; done_cnt[1] = 0; high_cnt[1] = 0;
    start_b = 1'b1;
    t0 = cyc + 1;
    step(1);
    start_b = 1'b0;
    chk("b_prime_busy", int'(busy_b), 1);
    chk("b_prime_rd_addr", int'(rd_addr_b), 0);
    wait_done(1, 400);
    chk("b_done_time", done_cyc[1] - t0, 1 + 65 * DIV_B);
    chk("b_bytes_rx", rx_cnt[1], 4);
    chk("b_rd_en_count", rden_cnt[1], 4);
    chk("b_queue_drained", exp_b.size(), 0);
    step(2);
  endtask

  initial begin
    int t0;
    for (int i = 0; i < 600; i++) mem_a[i] = i[7:0];
    for (int d = 0; d < 2; d++) begin
      rx_cnt[d] = 0; rden_cnt[d] = 0; done_cnt[d] = 0; done_cyc[d] = 0;
      run_len[d] = 0; high_cnt[d] = 0; rx_bits[d] = 0; rx_sr[d] = 8'd0;
    end
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    step(3);
    chk("rst_ss", int'(ss_a), 1);
    chk("rst_sclk", int'(sclk_a), 0);
    chk("rst_mosi", int'(mosi_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_rd_en", int'(rd_en_a), 0);
    chk("rst_rd_addr", int'(rd_addr_a), 0);
    rst = 1'b0;
    step(2);

    run_b(8'hA5, 8'h3C, 8'hFF, 8'h00);
    run_b(8'h80, 8'h80, 8'h80, 8'h80);
    chk("b_mosi_high_cycles", high_cnt[1], 4 * 2 * DIV_B);

    for (int i = 0; i < 600; i++) exp_a.push_back(i[7:0]);
    rden_cnt[0] = 0; rx_cnt[0] = 0; done_cnt[0] = 0;
    start_a = 1'b1;
    t0 = cyc + 1;
    step(1);
    start_a = 1'b0;
    chk("a_prime_busy", int'(busy_a), 1);
    chk("a_prime_rd_en", int'(rd_en_a), 1);
    chk("a_prime_rd_addr", int'(rd_addr_a), 0);
    step(1);
    chk("a_lead_ss", int'(ss_a), 0);
    step(48);
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    wait_done(0, 20000);
    chk("a_done_time", done_cyc[0] - t0, 1 + 9601 * DIV_A);
    chk("a_rd_en_count", rden_cnt[0], 600);
    chk("a_bytes_rx", rx_cnt[0], 600);
    chk("a_queue_drained", exp_a.size(), 0);
    chk("a_done_ss", int'(ss_a), 1);

    start_a = 1'b1;
    step(1);
    chk("a_done_cycle_start_ignored", int'(busy_a), 0);
    chk("a_single_done", done_cnt[0], 1);
    rx_cnt[0] = 0;
    for (int i = 0; i < 600; i++) exp_a.push_back(i[7:0]);
    t0 = cyc + 1;
    step(1);
    start_a = 1'b0;
    chk("a_restart_busy", int'(busy_a), 1);
    chk("a_restart_rd_en", int'(rd_en_a), 1);
    chk("a_restart_rd_addr", int'(rd_addr_a), 0);

    step(175 - (cyc - t0));
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("abort_ss", int'(ss_a), 1);
    chk("abort_sclk", int'(sclk_a), 0);
    chk("abort_mosi", int'(mosi_a), 0);
    chk("abort_busy", int'(busy_a), 0);
    chk("abort_rd_en", int'(rd_en_a), 0);
    chk("abort_rd_addr", int'(rd_addr_a), 0);
    chk("abort_bytes_rx", rx_cnt[0], 5);
    exp_a.delete();
    step(40);
    chk("abort_stays_idle", int'(ss_a), 1);
    chk("abort_no_partial_byte", rx_cnt[0], 5);

    rx_cnt[0] = 0;
    for (int i = 0; i < 600; i++) exp_a.push_back(i[7:0]);
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    chk("post_abort_rd_en", int'(rd_en_a), 1);
    chk("post_abort_rd_addr", int'(rd_addr_a), 0);
    step(70);
    chk("post_abort_bytes_rx", rx_cnt[0], 2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    exp_a.delete();
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
